// File: rtl/noc_eject_rx.sv
// noc_eject_rx: buffers router-ejected flits per VC, tracks per-VC packet locks,
// and re-serialises whole packets to the core over a valid/ready stream.
module noc_eject_rx #(
   parameter int DATAW = 66,
   parameter int VCN   = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATAW-1:0]         idata,
   input  logic                     ivalid,
   input  logic [$clog2(VCN)-1:0]   ivch,
   output logic [VCN-1:0]           oack,
   output logic [VCN-1:0]           olck,
   output logic [DATAW-1:0]         pdata,
   output logic                     pvalid,
   output logic                     psop,
   output logic                     peop,
   output logic [$clog2(VCN)-1:0]   pvch,
   input  logic                     pready,
   output logic [15:0]              pkt_cnt,
   output logic                     ovf_err,
   output logic                     proto_err
);
   localparam int VW = $clog2(VCN);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULLC = CW'(DEPTH);
   localparam logic [CW-1:0] ACKC  = CW'(DEPTH - 2);
   // flit type encodings from define.h
   localparam logic [1:0] TYPE_HEAD = 2'b11;
   localparam logic [1:0] TYPE_DATA = 2'b10;
   localparam logic [1:0] TYPE_TAIL = 2'b01;
   localparam logic [1:0] TYPE_NONE = 2'b00;

   typedef enum logic {IDLE, BUSY} state_t;

   logic [DATAW-1:0] mem [VCN][DEPTH];
   logic [AW-1:0]    wptr [VCN];
   logic [AW-1:0]    rptr [VCN];
   logic [CW-1:0]    count [VCN];
   logic [VCN-1:0]   full, empty, push, pop;
   logic [1:0]       ityp, ptyp;
   logic             typed, legal, wr_ok, hs, tail_pop, any;
   logic [VW-1:0]    grant, rr_ptr, winner, idx;
   logic [DATAW-1:0] front;
   state_t           state, state_nxt;

   assign ityp  = idata[DATAW-1:DATAW-2];
   assign typed = ivalid & (ityp != TYPE_NONE);
   assign legal = (ityp == TYPE_HEAD) ? !olck[ivch] :
                  (ityp == TYPE_DATA || ityp == TYPE_TAIL) ? olck[ivch] : 1'b0;
   assign wr_ok = typed & !full[ivch] & legal;
   assign push  = wr_ok ? (VCN'(1) << ivch) : '0;

   always_comb begin
      full  = '0;
      empty = '0;
      oack  = '0;
      for (int v = 0; v < VCN; v++) begin
         full[v]  = count[v] == FULLC;
         empty[v] = count[v] == '0;
         oack[v]  = count[v] <= ACKC;
      end
   end

   always_ff @(posedge clk)
      if (wr_ok) mem[ivch][wptr[ivch]] <= idata;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int v = 0; v < VCN; v++) begin
            wptr[v]  <= '0;
            rptr[v]  <= '0;
            count[v] <= '0;
         end
         olck      <= '0;
         ovf_err   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         for (int v = 0; v < VCN; v++) begin
            if (push[v]) wptr[v] <= wptr[v] + 1'b1;
            if (pop[v]) rptr[v] <= rptr[v] + 1'b1;
            count[v] <= count[v] + CW'(push[v]) - CW'(pop[v]);
            if (push[v] && ityp == TYPE_HEAD) olck[v] <= 1'b1;
            if (push[v] && ityp == TYPE_TAIL) olck[v] <= 1'b0;
         end
         if (typed && full[ivch]) ovf_err <= 1'b1;
         if (typed && !full[ivch] && !legal) proto_err <= 1'b1;
      end

   // descending scan so the VC closest to rr_ptr wins
   always_comb begin
      any    = 1'b0;
      winner = rr_ptr;
      idx    = rr_ptr;
      for (int i = VCN - 1; i >= 0; i--) begin
         idx = rr_ptr + VW'(i);
         if (!empty[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
   end

   assign front    = mem[grant][rptr[grant]];
   assign ptyp     = front[DATAW-1:DATAW-2];
   assign pvalid   = (state == BUSY) & !empty[grant];
   assign pdata    = pvalid ? front : '0;
   assign psop     = pvalid & (ptyp == TYPE_HEAD);
   assign peop     = pvalid & (ptyp == TYPE_TAIL);
   assign pvch     = grant;
   assign hs       = pvalid & pready;
   assign pop      = hs ? (VCN'(1) << grant) : '0;
   assign tail_pop = hs & peop;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (state == IDLE) state_nxt = any ? BUSY : IDLE;
      else state_nxt = tail_pop ? IDLE : BUSY;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         grant   <= '0;
         rr_ptr  <= '0;
         pkt_cnt <= '0;
      end else begin
         if (state == IDLE && any) grant <= winner;
         if (tail_pop) rr_ptr <= grant + 1'b1;
         pkt_cnt <= pkt_cnt + 16'(tail_pop);
      end
endmodule

// File: tb/tb_noc_eject_rx.sv
// tb_noc_eject_rx: directed checks of packet delivery, backpressure, error flags,
// mid-packet reset and packet counter wrap.
module tb_noc_eject_rx;
   localparam int DATAW = 66;
   localparam int VCN   = 4;
   localparam int DEPTH = 4;
   localparam logic [1:0] H = 2'b11;
   localparam logic [1:0] D = 2'b10;
   localparam logic [1:0] T = 2'b01;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [DATAW-1:0] idata = '0;
   logic             ivalid = 1'b0;
   logic [1:0]       ivch = '0;
   logic [VCN-1:0]   oack, olck;
   logic [DATAW-1:0] pdata;
   logic             pvalid, psop, peop, pready = 1'b0;
   logic [1:0]       pvch;
   logic [15:0]      pkt_cnt;
   logic             ovf_err, proto_err;

   int total = 0;
   int passed = 0;
   int cyc = 0;
   logic [DATAW+3:0] q[$];
   int qc[$];

   noc_eject_rx #(.DATAW(DATAW), .VCN(VCN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch),
      .oack(oack), .olck(olck), .pdata(pdata), .pvalid(pvalid), .psop(psop),
      .peop(peop), .pvch(pvch), .pready(pready), .pkt_cnt(pkt_cnt),
      .ovf_err(ovf_err), .proto_err(proto_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk)
      if (pvalid && pready) begin
         q.push_back({pvch, psop, peop, pdata});
         qc.push_back(cyc);
      end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [DATAW+3:0] obs, input logic [DATAW+3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [DATAW+3:0] er(input int v, input logic [1:0] t, input logic [63:0] p);
      return {2'(v), t == H, t == T, t, p};
   endfunction

   function automatic logic [1:0] ft(input int f);
      return f == 0 ? H : f == 5 ? T : D;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v, input logic [1:0] t, input logic [63:0] p);
      ivalid = 1'b1;
      ivch   = 2'(v);
      idata  = {t, p};
      tick();
      ivalid = 1'b0;
      idata  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      q.delete();
      qc.delete();
   endtask

   task automatic wait_q(input int n);
      int k = 0;
      while (q.size() < n && k < 300) begin
         tick();
         k++;
      end
   endtask

   initial begin
      int nf[4];
      int v, k, sel;
      tick();
      tick();
      chk("rst_oack", oack, 4'hF);
      chk("rst_olck", olck, 0);
      chk("rst_pvalid", pvalid, 0);
      chk("rst_psop", psop, 0);
      chk("rst_peop", peop, 0);
      chk("rst_pvch", pvch, 0);
      chk("rst_pdata", pdata, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_ovf", ovf_err, 0);
      chk("rst_proto", proto_err, 0);
      rst = 1'b0;
      tick();

      pready = 1'b1;
      send(0, H, 64'h9);
      chk("t1_olck_head", olck, 4'h1);
      chk("t1_pvalid_lat1", pvalid, 0);
      send(0, D, 64'h1);
      chk("t1_pvalid_lat2", pvalid, 1);
      chk("t1_psop", psop, 1);
      chk("t1_pdata_head", pdata, {H, 64'h9});
      send(0, D, 64'h2);
      send(0, D, 64'h3);
      send(0, D, 64'h4);
      chk("t1_olck_mid", olck, 4'h1);
      send(0, T, 64'h5);
      chk("t1_olck_tail", olck, 4'h0);
      wait_q(6);
      tick();
      chk("t1_qsize", q.size(), 6);
      chk("t1_f0", q[0], er(0, H, 64'h9));
      for (int i = 1; i < 5; i++) chk("t1_fdata", q[i], er(0, D, 64'(i)));
      chk("t1_f5", q[5], er(0, T, 64'h5));
      chk("t1_pkt_cnt", pkt_cnt, 1);

      do_reset();
      pready = 1'b1;
      for (int i = 0; i < 4; i++) nf[i] = 0;
      v = 0;
      k = 0;
      while ((nf[0] + nf[1] + nf[2] + nf[3]) < 24 && k < 500) begin
         sel = -1;
         for (int j = VCN - 1; j >= 0; j--)
            if (nf[(v + j) % 4] < 6 && oack[(v + j) % 4]) sel = (v + j) % 4;
         if (sel >= 0) begin
            send(sel, ft(nf[sel]), 64'(sel * 16 + nf[sel]));
            nf[sel]++;
            v = (sel + 1) % 4;
         end else tick();
         k++;
      end
      wait_q(24);
      tick();
      chk("t2_qsize", q.size(), 24);
      for (int i = 0; i < 24 && i < q.size(); i++)
         chk("t2_flit", q[i], er(i / 6, ft(i % 6), 64'((i / 6) * 16 + i % 6)));
      for (int p = 1; p < 4 && 6 * p < qc.size(); p++)
         chk("t2_idle_gap", qc[6 * p] - qc[6 * p - 1], 2);
      chk("t2_pkt_cnt", pkt_cnt, 4);

      do_reset();
      pready = 1'b0;
      send(1, H, 64'h10);
      chk("t3_oack_1", oack[1], 1);
      send(1, D, 64'h11);
      chk("t3_oack_2", oack[1], 1);
      send(1, D, 64'h12);
      chk("t3_oack_3", oack[1], 0);
      send(1, D, 64'h13);
      chk("t3_ovf_before", ovf_err, 0);
      send(1, D, 64'h14);
      chk("t3_ovf_after", ovf_err, 1);
      chk("t3_olck", olck, 4'h2);
      chk("t3_hold_pvalid", pvalid, 1);
      chk("t3_hold_pdata", pdata, {H, 64'h10});
      tick();
      tick();
      chk("t3_stable_pvalid", pvalid, 1);
      chk("t3_stable_pdata", pdata, {H, 64'h10});
      chk("t3_stable_psop", psop, 1);
      chk("t3_stable_pvch", pvch, 1);
      pready = 1'b1;
      repeat (8) tick();
      chk("t3_qsize", q.size(), 4);
      if (q.size() == 4) chk("t3_last", q[3], er(1, D, 64'h13));
      chk("t3_oack_drained", oack, 4'hF);

      do_reset();
      pready = 1'b0;
      send(2, D, 64'h20);
      chk("t4_proto", proto_err, 1);
      tick();
      tick();
      chk("t4_vc2_empty", pvalid, 0);
      chk("t4_olck_none", olck, 0);
      send(3, H, 64'h30);
      send(3, H, 64'h31);
      chk("t4_olck3", olck, 4'h8);
      chk("t4_ovf", ovf_err, 0);
      pready = 1'b1;
      repeat (6) tick();
      chk("t4_qsize", q.size(), 1);
      if (q.size() == 1) chk("t4_flit", q[0], er(3, H, 64'h30));
      chk("t4_proto_sticky", proto_err, 1);

      do_reset();
      pready = 1'b1;
      send(1, H, 64'h40);
      send(1, T, 64'h41);
      wait_q(2);
      tick();
      chk("t5_pkt_pre", pkt_cnt, 1);
      send(0, H, 64'h50);
      send(0, D, 64'h51);
      send(0, D, 64'h52);
      wait_q(5);
      chk("t5_olck_pre", olck, 4'h1);
      rst = 1'b1;
      #1;
      chk("t5_oack", oack, 4'hF);
      chk("t5_olck", olck, 0);
      chk("t5_pvalid", pvalid, 0);
      chk("t5_pdata", pdata, 0);
      chk("t5_pkt_cnt", pkt_cnt, 0);
      tick();
      rst = 1'b0;
      tick();
      q.delete();
      qc.delete();
      send(2, H, 64'h60);
      send(2, T, 64'h61);
      wait_q(2);
      tick();
      chk("t5_qsize", q.size(), 2);
      if (q.size() == 2) begin
         chk("t5_head", q[0], er(2, H, 64'h60));
         chk("t5_tail", q[1], er(2, T, 64'h61));
      end
      chk("t5_pkt_post", pkt_cnt, 1);

      force dut.pkt_cnt = 16'hFFFE;
      tick();
      release dut.pkt_cnt;
      tick();
      chk("t6_preload", pkt_cnt, 16'hFFFE);
      q.delete();
      send(0, H, 64'h70);
      send(0, T, 64'h71);
      wait_q(2);
      tick();
      chk("t6_ffff", pkt_cnt, 16'hFFFF);
      send(3, H, 64'h72);
      send(3, T, 64'h73);
      wait_q(4);
      tick();
      chk("t6_wrap", pkt_cnt, 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
